eq2_pair_driver: RTL and testbench

//  Stimulus/check end of the 2-bit equality-comparator interface: drives every
//  (a,b) operand pair into a comparator under test and samples its aeqb result.

---
 rtl/eq2_pair_driver.sv | 132 +++++++++++++
 tb/tb_eq2_pair_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eq2_pair_driver.sv
// Self-test driver for a W-bit equality comparator: walks every (a,b) pair,
// holds each for SETTLE cycles, samples aeqb_in and tallies matches and errors.
module eq2_pair_driver #(
  parameter int W      = 2,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic           aeqb_in,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   eq_cnt,
  output logic [2*W:0]   err_cnt,
  output logic [W-1:0]   first_err_a,
  output logic [W-1:0]   first_err_b,
  output logic [1:0]     state_o
);

  localparam int PW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q;
  logic [PW-1:0]   pair_q;
  logic [SW-1:0]   settle_q;
  logic            busy_q, done_q, pass_q;
  logic [CW-1:0]   eq_cnt_q, err_cnt_q;
  logic [W-1:0]    first_err_a_q, first_err_b_q;

  logic            exp_eq, is_err, is_last;
  logic [PW-1:0]   pair_d;
  logic [CW-1:0]   err_cnt_d;

  always_comb begin
    exp_eq    = (pair_q[PW-1:W] == pair_q[W-1:0]);
    is_err    = (aeqb_in != exp_eq);
    is_last   = (pair_q == {PW{1'b1}});
    pair_d    = pair_q + 1'b1;
    err_cnt_d = err_cnt_q + CW'(is_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pair_q        <= '0;
      settle_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      eq_cnt_q      <= '0;
      err_cnt_q     <= '0;
      first_err_a_q <= '0;
      first_err_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort outranks start here, so a simultaneous pair leaves us idle
          if (start && !abort) begin
            eq_cnt_q      <= '0;
            err_cnt_q     <= '0;
            first_err_a_q <= '0;
            first_err_b_q <= '0;
            pass_q        <= 1'b0;
            pair_q        <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b1;
            state_q       <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (settle_q == SW'(SETTLE - 1)) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (!is_err && exp_eq) eq_cnt_q <= eq_cnt_q + 1'b1;
            if (is_err) begin
              err_cnt_q <= err_cnt_d;
              if (err_cnt_q == '0) begin
                first_err_a_q <= pair_q[PW-1:W];
                first_err_b_q <= pair_q[W-1:0];
              end
            end
            if (is_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
              state_q <= DONE;
            end else begin
              pair_q   <= pair_d;
              settle_q <= '0;
              state_q  <= DRIVE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out       = pair_q[PW-1:W];
  assign b_out       = pair_q[W-1:0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign eq_cnt      = eq_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign first_err_a = first_err_a_q;
  assign first_err_b = first_err_b_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_eq2_pair_driver.sv
// Bench for eq2_pair_driver: table of comparator behaviours, randomized fault
// patterns against a pair-walk model, and abort/reset/restart corner sequences.
module tb_eq2_pair_driver;

  localparam int ST_IDLE   = 0;
  localparam int ST_SAMPLE = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, aeqb;
  logic [1:0] a_out, b_out, first_err_a, first_err_b, state_o;
  logic       busy, done, pass;
  logic [4:0] eq_cnt, err_cnt;

  logic       start3, aeqb3;
  logic [1:0] a3, b3, fa3, fb3, st3;
  logic       busy3, done3, pass3;
  logic [4:0] eq3, err3;

  int          mode;
  logic [15:0] flip;
  logic        d1, d2, d3, e1, e2, e3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eq2_pair_driver #(.W(2), .SETTLE(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .aeqb_in(aeqb),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .eq_cnt(eq_cnt), .err_cnt(err_cnt), .first_err_a(first_err_a),
    .first_err_b(first_err_b), .state_o(state_o)
  );

  eq2_pair_driver #(.W(2), .SETTLE(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .abort(1'b0), .aeqb_in(aeqb3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .eq_cnt(eq3), .err_cnt(err3), .first_err_a(fa3),
    .first_err_b(fb3), .state_o(st3)
  );

  // Comparator under test: several behaviours selected by mode
  always_comb begin
    aeqb = 1'b0;
    case (mode)
      0: aeqb = (a_out == b_out);
      1: aeqb = 1'b1;
      2: aeqb = 1'b0;
      3: aeqb = d3;
      default: aeqb = (a_out == b_out) ^ flip[{a_out, b_out}];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
      e1 <= 1'b0; e2 <= 1'b0; e3 <= 1'b0;
    end else begin
      d1 <= (a_out == b_out); d2 <= d1; d3 <= d2;
      e1 <= (a3 == b3);       e2 <= e1; e3 <= e2;
    end
  end
  assign aeqb3 = e3;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Reference: walk all 16 pairs, derive what the comparator reports for each
  function automatic void model(input int md, input logic [15:0] fl,
                                output int e_eq, output int e_err,
                                output int e_fa, output int e_fb, output bit e_pass);
    e_eq = 0; e_err = 0; e_fa = 0; e_fb = 0;
    for (int p = 0; p < 16; p++) begin
      int  a = p / 4;
      int  b = p % 4;
      bit  exp_r = (a == b);
      bit  got;
      case (md)
        0:       got = exp_r;
        1:       got = 1'b1;
        2:       got = 1'b0;
        default: got = exp_r ^ fl[p];
      endcase
      if (got == exp_r && exp_r) e_eq++;
      if (got != exp_r) begin
        if (e_err == 0) begin e_fa = a; e_fb = b; end
        e_err++;
      end
    end
    e_pass = (e_err == 0);
  endfunction

  task automatic do_run(input bit poke, output int cyc, output bit seq_ok);
    logic [3:0] exp_q[$];
    logic [3:0] e;
    exp_q.delete();
    for (int p = 0; p < 16; p++)
      for (int k = 0; k < 3; k++) exp_q.push_back(4'(p));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; seq_ok = 1'b1;
    while (busy && cyc < 200) begin
      if (exp_q.size() == 0) seq_ok = 1'b0;
      else begin
        e = exp_q.pop_front();
        if ({a_out, b_out} != e) seq_ok = 1'b0;
      end
      cyc++;
      start = poke && (cyc == 10);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input bit poke, input int x_eq,
                               input int x_err, input int x_fa, input int x_fb,
                               input bit x_pass);
    int cyc;
    bit seq_ok;
    do_run(poke, cyc, seq_ok);
    check({nm, "_busy_cycles"}, cyc, 48);
    check({nm, "_pair_order"}, int'(seq_ok), 1);
    check({nm, "_done"}, int'(done), 1);
    check({nm, "_eq_cnt"}, int'(eq_cnt), x_eq);
    check({nm, "_err_cnt"}, int'(err_cnt), x_err);
    check({nm, "_first_err_a"}, int'(first_err_a), x_fa);
    check({nm, "_first_err_b"}, int'(first_err_b), x_fb);
    check({nm, "_pass"}, int'(pass), int'(x_pass));
    @(negedge clk);
    check({nm, "_done_pulse"}, int'(done), 0);
    check({nm, "_pass_hold"}, int'(pass), int'(x_pass));
  endtask

  typedef struct {
    int md; int eq; int err; int fa; int fb; bit pass;
  } vec_t;

  initial begin
    vec_t tbl[3];
    int   m_eq, m_err, m_fa, m_fb;
    bit   m_pass;
    int   cyc, cnt;
    bit   seq_ok;

    tbl[0] = '{md: 0, eq: 4, err: 0,  fa: 0, fb: 0, pass: 1'b1};
    tbl[1] = '{md: 1, eq: 4, err: 12, fa: 0, fb: 1, pass: 1'b0};
    tbl[2] = '{md: 2, eq: 0, err: 4,  fa: 0, fb: 0, pass: 1'b0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    mode = 0; flip = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_ab", int'({a_out, b_out}), 0);
    check("rst_counts", int'({eq_cnt, err_cnt}), 0);
    check("rst_state", int'(state_o), ST_IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      mode = tbl[i].md;
      run_and_check($sformatf("tbl%0d", i), 1'b0, tbl[i].eq, tbl[i].err,
                    tbl[i].fa, tbl[i].fb, tbl[i].pass);
    end

    for (int r = 0; r < 6; r++) begin
      mode = 4;
      flip = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
      if (r == 0) flip = '0;
      model(4, flip, m_eq, m_err, m_fa, m_fb, m_pass);
      run_and_check($sformatf("rand%0d", r), 1'b0, m_eq, m_err, m_fa, m_fb, m_pass);
    end

    mode = 0;
    run_and_check("restart_poke", 1'b1, 4, 0, 0, 0, 1'b1);

    // Comparator slower than the settle window
    mode = 3;
    do_run(1'b0, cyc, seq_ok);
    check("slow_done", int'(done), 1);
    check("slow_err_nonzero", int'(err_cnt != 0), 1);
    check("slow_pass", int'(pass), 0);
    @(negedge clk);

    // Same slow comparator with a 3-cycle window
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    cnt = 0;
    while (busy3 && cnt < 300) begin cnt++; @(negedge clk); end
    check("s3_busy_cycles", cnt, 64);
    check("s3_done", int'(done3), 1);
    check("s3_err_cnt", int'(err3), 0);
    check("s3_eq_cnt", int'(eq3), 4);
    check("s3_pass", int'(pass3), 1);

    // start and abort together in IDLE
    mode = 0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle_state", int'(state_o), ST_IDLE);
    check("start_abort_idle_busy", int'(busy), 0);

    // abort in the SAMPLE of pair 5
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!(int'(state_o) == ST_SAMPLE && a_out == 2'd1 && b_out == 2'd1) && cnt < 100) begin
      cnt++; @(negedge clk);
    end
    check("abort_reached_pair5", int'(cnt < 100), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_state", int'(state_o), ST_IDLE);
    check("abort_busy", int'(busy), 0);
    check("abort_eq_cnt", int'(eq_cnt), 1);
    check("abort_err_cnt", int'(err_cnt), 0);
    check("abort_ab_hold", int'({a_out, b_out}), 5);
    cnt = 0;
    repeat (5) begin if (done || pass) cnt++; @(negedge clk); end
    check("abort_no_done", cnt, 0);
    run_and_check("after_abort", 1'b0, 4, 0, 0, 0, 1'b1);

    // Reset mid-run at pair 7
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!(a_out == 2'd1 && b_out == 2'd3) && cnt < 100) begin cnt++; @(negedge clk); end
    check("rst_mid_reached_pair7", int'(cnt < 100), 1);
    check("rst_mid_eq_before", int'(eq_cnt), 2);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ab", int'({a_out, b_out}), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_counts", int'({eq_cnt, err_cnt}), 0);
    check("rst_mid_state", int'(state_o), ST_IDLE);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    run_and_check("after_reset", 1'b0, 4, 0, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
